// File: rtl/line_animator.sv
// Frame sequencer for line_drawer: erases the previous line, walks the endpoint
// one step around the screen perimeter, redraws from the centre, then holds.
module line_animator #(
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned STEP        = 8,
  parameter int unsigned WAIT_CYCLES = 833333,
  parameter int unsigned COORD_W     = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               done,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic               color,
  output logic               start,
  output logic               busy,
  output logic [15:0]        frame_count
);

  localparam int unsigned EXT_W  = COORD_W + 1;
  localparam int unsigned HOLD_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [COORD_W-1:0] CX        = COORD_W'(X_MAX / 2);
  localparam logic [COORD_W-1:0] CY        = COORD_W'(Y_MAX / 2);
  localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(Y_MAX);
  localparam logic [EXT_W-1:0]   STEP_E    = EXT_W'(STEP);
  localparam logic [EXT_W-1:0]   XMAX_E    = EXT_W'(X_MAX);
  localparam logic [EXT_W-1:0]   YMAX_E    = EXT_W'(Y_MAX);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_START,
    S_ERASE_WAIT,
    S_ADVANCE,
    S_DRAW_START,
    S_DRAW_WAIT,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    E_TOP,
    E_RIGHT,
    E_BOTTOM,
    E_LEFT
  } side_t;

  state_t              state_q, state_d;
  side_t               side_q, side_d;
  logic                drawn_q, drawn_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [COORD_W-1:0]  x1_d, y1_d;
  logic                color_d, start_d, busy_d;
  logic [15:0]         fc_d;
  logic [EXT_W-1:0]    x_ext, y_ext, x_inc, y_inc;

  // Next-state and next-output logic; registered below so every output is a flop.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    drawn_d = drawn_q;
    hold_d  = hold_q;
    x1_d    = x1;
    y1_d    = y1;
    color_d = color;
    fc_d    = frame_count;
    x_ext   = {1'b0, x1};
    y_ext   = {1'b0, y1};
    x_inc   = x_ext + STEP_E;
    y_inc   = y_ext + STEP_E;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = drawn_q ? S_ERASE_START : S_ADVANCE;
      end
      S_ERASE_START: state_d = S_ERASE_WAIT;
      S_ERASE_WAIT: begin
        if (done) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        state_d = S_DRAW_START;
        // A clamp to the corner is this frame's whole move.
        case (side_q)
          E_TOP: begin
            if (x_inc >= XMAX_E) begin
              x1_d   = X_LIM;
              side_d = E_RIGHT;
            end else begin
              x1_d = x_inc[COORD_W-1:0];
            end
          end
          E_RIGHT: begin
            if (y_inc >= YMAX_E) begin
              y1_d   = Y_LIM;
              side_d = E_BOTTOM;
            end else begin
              y1_d = y_inc[COORD_W-1:0];
            end
          end
          E_BOTTOM: begin
            if (x_ext < STEP_E) begin
              x1_d   = '0;
              side_d = E_LEFT;
            end else begin
              x1_d = COORD_W'(x_ext - STEP_E);
            end
          end
          E_LEFT: begin
            if (y_ext < STEP_E) begin
              y1_d   = '0;
              side_d = E_TOP;
            end else begin
              y1_d = COORD_W'(y_ext - STEP_E);
            end
          end
        endcase
      end
      S_DRAW_START: state_d = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (done) begin
          state_d = S_HOLD;
          drawn_d = 1'b1;
          fc_d    = frame_count + 16'd1;
          hold_d  = HOLD_LAST;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) state_d = enable ? S_ERASE_START : S_IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERASE_START)     color_d = 1'b0;
    else if (state_d == S_DRAW_START) color_d = 1'b1;
    start_d = (state_d == S_ERASE_START) || (state_d == S_DRAW_START);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      side_q      <= E_TOP;
      drawn_q     <= 1'b0;
      hold_q      <= '0;
      x0          <= CX;
      y0          <= CY;
      x1          <= '0;
      y1          <= '0;
      color       <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      drawn_q     <= drawn_d;
      hold_q      <= hold_d;
      x0          <= CX;
      y0          <= CY;
      x1          <= x1_d;
      y1          <= y1_d;
      color       <= color_d;
      start       <= start_d;
      busy        <= busy_d;
      frame_count <= fc_d;
    end
  end

endmodule

// File: tb/tb_line_animator.sv
// Randomised bench for line_animator: a drawer model answers each start, and a
// perimeter-walk reference checks every erase/draw request and its timing.
module tb_line_animator;

  localparam int unsigned XM = 31;
  localparam int unsigned YM = 23;
  localparam int unsigned ST = 8;
  localparam int unsigned WC = 4;
  localparam int unsigned CW = 11;

  logic          clk, reset, enable, done;
  logic [CW-1:0] x0, y0, x1, y1;
  logic          color, start, busy;
  logic [15:0]   frame_count;

  line_animator #(
    .X_MAX(XM), .Y_MAX(YM), .STEP(ST), .WAIT_CYCLES(WC), .COORD_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .done(done),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .color(color), .start(start), .busy(busy), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: ordered list of endpoints visited along the perimeter.
  int lap_x[$];
  int lap_y[$];
  int idx;
  int mfc;
  bit expect_erase;
  bit fc_pending;
  bit last_valid;
  int last_kind;
  int last_done_cyc;
  bit en_low;
  bit spur_en;
  int cyc = 0;
  int win;
  int cap_x, cap_y, cap_c;
  logic prev_start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_lap();
    int x, y;
    x = 0;
    while (x + ST < XM) begin x += ST; lap_x.push_back(x); lap_y.push_back(0); end
    lap_x.push_back(XM); lap_y.push_back(0);
    y = 0;
    while (y + ST < YM) begin y += ST; lap_x.push_back(XM); lap_y.push_back(y); end
    lap_x.push_back(XM); lap_y.push_back(YM);
    x = XM;
    while (x >= ST) begin x -= ST; lap_x.push_back(x); lap_y.push_back(YM); end
    lap_x.push_back(0); lap_y.push_back(YM);
    y = YM;
    while (y >= ST) begin y -= ST; lap_x.push_back(0); lap_y.push_back(y); end
    lap_x.push_back(0); lap_y.push_back(0);
  endtask

  function automatic int cur_x();
    return (idx < 0) ? 0 : lap_x[idx];
  endfunction

  function automatic int cur_y();
    return (idx < 0) ? 0 : lap_y[idx];
  endfunction

  task automatic model_reset();
    idx          = -1;
    mfc          = 0;
    expect_erase = 1'b0;
    fc_pending   = 1'b0;
    last_valid   = 1'b0;
    win          = 0;
    done         = 1'b0;
    prev_start   = 1'b0;
  endtask

  // One clock: observe just after the edge, check, then drive done for this cycle.
  task automatic tick();
    int ex, ey, ec, gap;
    @(posedge clk);
    #1;
    cyc++;
    if (fc_pending) begin
      chk("frame_count_post", 32'(frame_count), 32'(mfc));
      fc_pending = 1'b0;
    end
    if (start === 1'b1) begin
      chk("start_single", 32'(prev_start), 0);
      if (expect_erase) begin
        ec = 0;
        expect_erase = 1'b0;
      end else begin
        idx = (idx + 1) % lap_x.size();
        ec = 1;
      end
      ex = cur_x();
      ey = cur_y();
      chk("start_color", 32'(color), 32'(ec));
      chk("start_x1", 32'(x1), 32'(ex));
      chk("start_y1", 32'(y1), 32'(ey));
      if (last_valid) begin
        gap = cyc - last_done_cyc;
        if (last_kind == 0) chk("gap_erase", 32'(gap), 2);
        else if (!en_low)   chk("gap_draw", 32'(gap), WC + 1);
        last_valid = 1'b0;
      end
      cap_x = ex;
      cap_y = ey;
      cap_c = ec;
      win   = 3;
      done  = spur_en && ($urandom_range(0, 2) == 0);
    end else if (win > 0) begin
      chk("wait_x1", 32'(x1), 32'(cap_x));
      chk("wait_y1", 32'(y1), 32'(cap_y));
      chk("wait_color", 32'(color), 32'(cap_c));
      win--;
      done = (win == 0);
      if (win == 0) begin
        last_done_cyc = cyc;
        last_kind     = cap_c;
        last_valid    = 1'b1;
        if (cap_c == 1) begin
          chk("frame_count_pre", 32'(frame_count), 32'(mfc));
          mfc          = (mfc + 1) & 16'hFFFF;
          expect_erase = 1'b1;
          fc_pending   = 1'b1;
          if (enable) en_low = 1'b0;
        end
      end
    end else begin
      done = spur_en && ($urandom_range(0, 2) == 0);
    end
    prev_start = start;
  endtask

  task automatic wait_draw_start(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (start === 1'b1 && color === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Called on a DRAW_START cycle: drop enable, let the frame finish, idle, resume.
  task automatic drop_enable(input int idle_len);
    tick();
    enable = 1'b0;
    en_low = 1'b1;
    for (int i = 0; i < 10 && !(last_valid && last_done_cyc == cyc); i++) tick();
    if (!(last_valid && last_done_cyc == cyc)) chk("drop_done_timeout", 0, 1);
    for (int i = 0; i < WC; i++) begin
      tick();
      chk("hold_busy", 32'(busy), 1);
      chk("hold_start", 32'(start), 0);
    end
    tick();
    chk("idle_busy", 32'(busy), 0);
    for (int i = 1; i < idle_len; i++) begin
      tick();
      chk("idle_busy_stay", 32'(busy), 0);
      chk("idle_start_stay", 32'(start), 0);
    end
    enable = 1'b1;
    tick();
    chk("reenable_start", 32'(start), 1);
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b1;
    done    = 1'b0;
    spur_en = 1'b0;
    en_low  = 1'b0;
    build_lap();
    model_reset();

    // Reset values held while reset is low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_start", 32'(start), 0);
      chk("rst_color", 32'(color), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      chk("rst_x0", 32'(x0), XM / 2);
      chk("rst_y0", 32'(y0), YM / 2);
      chk("rst_x1", 32'(x1), 0);
      chk("rst_y1", 32'(y1), 0);
    end

    // First frame: no erase, start two cycles after IDLE.
    reset = 1'b1;
    tick();
    chk("first_advance_start", 32'(start), 0);
    chk("first_advance_busy", 32'(busy), 1);
    tick();
    chk("first_draw_start", 32'(start), 1);

    // Full lap back to the first point.
    for (int f = 0; f < 14; f++) wait_draw_start("lap");

    // Spurious done pulses and random enable drops.
    spur_en = 1'b1;
    for (int f = 0; f < 12; f++) begin
      wait_draw_start("rand");
      if ($urandom_range(0, 3) == 0) drop_enable($urandom_range(1, 5));
    end

    // Directed enable drop in DRAW_WAIT.
    wait_draw_start("drop");
    drop_enable(3);

    // Reset for one cycle in DRAW_WAIT.
    spur_en = 1'b0;
    wait_draw_start("pre_reset");
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk("post_rst_start", 32'(start), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_x1", 32'(x1), 0);
    chk("post_rst_y1", 32'(y1), 0);
    chk("post_rst_frame_count", 32'(frame_count), 0);
    reset = 1'b1;
    tick();
    chk("post_rst_advance", 32'(start), 0);
    tick();
    chk("post_rst_draw_start", 32'(start), 1);

    spur_en = 1'b1;
    for (int f = 0; f < 3; f++) wait_draw_start("tail");
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
